// File: rtl/stream_accumulator_pkg.sv
// Shared constants, state encoding and block-length decode
// for the stream accumulator.
package stream_accumulator_pkg;

  localparam int SA_WIDTH = 8;
  localparam int SA_LEN_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } sa_state_t;

  // A length field of zero encodes the full block of 2**LEN_W samples.
  function automatic logic [SA_LEN_W:0] decode_len(
    input logic [SA_LEN_W-1:0] l
  );
    logic [SA_LEN_W:0] r;
    r = {1'b0, l};
    if (l == '0) begin
      r = {1'b1, {SA_LEN_W{1'b0}}};
    end
    return r;
  endfunction

endpackage

// File: rtl/Adder.sv
// Existing 8-bit ripple-carry adder; sum only, the carry-out
// is not brought out.
module Adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] s
);

  logic [7:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < 8; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < 7) begin : g_carry
      assign c[i+1] = (a[i] & b[i])
                    | (a[i] & c[i])
                    | (b[i] & c[i]);
    end
  end

endmodule

// File: rtl/stream_accumulator.sv
// Sums a block of 1..16 samples through Adder and presents the
// 16-bit total {hi, lo} on a valid/ready result port.
module stream_accumulator
  import stream_accumulator_pkg::*;
#(
  parameter int WIDTH = SA_WIDTH,
  parameter int LEN_W = SA_LEN_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [LEN_W-1:0]   len,
  input  logic               in_valid,
  input  logic [WIDTH-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] sum,
  output logic               busy
);

  localparam logic [LEN_W:0] REM_ONE = 1;

  sa_state_t        state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [LEN_W:0]   rem_q, rem_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] s;
  logic             carry;

  Adder u_adder (
    .a (lo_q),
    .b (in_data),
    .s (s)
  );

  // The adder wrapped past 2**WIDTH exactly when its sum fell below lo.
  assign carry = (s < lo_q);

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          lo_d    = '0;
          hi_d    = '0;
          rem_d   = decode_len(len);
          state_d = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          lo_d  = s;
          hi_d  = hi_q + {{(WIDTH-1){1'b0}}, carry};
          rem_d = rem_q - REM_ONE;
          if (rem_q == REM_ONE) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready_d  = (state_d == ST_ACCUM);
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lo_q        <= '0;
      hi_q        <= '0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lo_q        <= lo_d;
      hi_q        <= hi_d;
      rem_q       <= rem_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = {hi_q, lo_q};

endmodule
